// File: rtl/fir4_pkg.sv
// Shared constants for the 4-tap moving-sum filter family (forward filter,
// inverse filter fir4_inv and their benches).
package fir4_pkg;

    localparam int TAPS = 4;

    // A 4-tap sum of w-bit unsigned samples needs two extra bits.
    function automatic int sum_width(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/fir4_tap_delay.sv
// Shift-register history of recovered samples; q is the oldest tap.
// One position per enabled cycle. clr and reset both zero every tap.
module fir4_tap_delay
    import fir4_pkg::*;
#(
    parameter int width = 7,
    parameter int depth = TAPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] tap_reg [depth];

    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_tap
            logic [width-1:0] tap_next;
            if (gi == 0) begin : g_head
                assign tap_next = d;
            end else begin : g_body
                assign tap_next = tap_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (reset || clr) begin
                    tap_reg[gi] <= '0;
                end else if (en) begin
                    tap_reg[gi] <= tap_next;
                end
            end
        end
    endgenerate

    assign q = tap_reg[depth-1];

endmodule

// File: rtl/fir4_inv.sv
// Inverse of the 4-tap moving-sum filter: x[k] = s[k] - s[k-1] + x[k-4].
// Optional sticky range check on x[k] enabled by macro FIR4_INV_CHECK_EN.
module fir4_inv
    import fir4_pkg::*;
#(
    parameter int w = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic [sum_width(w)-1:0] s_in,
    input  logic                    s_valid,
    output logic [w-1:0]            a_out,
    output logic                    a_valid,
    output logic                    err
);

    localparam int sw = sum_width(w);
    localparam int xw = w + 3;

    logic [sw-1:0]        s_prev_reg;
    logic [w-1:0]         a_out_reg;
    logic                 a_valid_reg;
    logic [xw-1:0]        oldest;
    logic signed [xw-1:0] x_next;
    logic                 accept;

    // A sample is taken only when neither reset nor clr is active.
    assign accept = s_valid && !clr;

    // History keeps the full signed value so an out-of-range sample still
    // cancels correctly four samples later.
    assign x_next = $signed({1'b0, s_in}) - $signed({1'b0, s_prev_reg})
                  + $signed(oldest);

    fir4_tap_delay #(
        .width (xw),
        .depth (TAPS)
    ) u_hist (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .clr   (clr),
        .d     (x_next),
        .q     (oldest)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s_prev_reg  <= '0;
            a_out_reg   <= '0;
            a_valid_reg <= 1'b0;
        end else if (clr) begin
            s_prev_reg  <= '0;
            a_valid_reg <= 1'b0;
        end else if (s_valid) begin
            s_prev_reg  <= s_in;
            a_out_reg   <= x_next[w-1:0];
            a_valid_reg <= 1'b1;
        end else begin
            a_valid_reg <= 1'b0;
        end
    end

    assign a_out   = a_out_reg;
    assign a_valid = a_valid_reg;

`ifdef FIR4_INV_CHECK_EN
    logic err_reg;
    logic out_of_range;

    // Any set bit above w (including sign) means x[k] left 0..2^w-1.
    assign out_of_range = x_next[xw-1:w] != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (accept && out_of_range) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/fir4_inv.md
FIR4_INV -- requirements
Module: fir4_inv

Interface
REQ-001 The block SHALL have parameter w, default 4, giving the width of the recovered unsigned sample.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous history clear, used mid-stream.
REQ-005 The block SHALL have port s_in, input, w+2 bits: unsigned 4-tap moving-sum sample from the forward filter.
REQ-006 The block SHALL have port s_valid, input, 1 bit: s_in is valid this cycle.
REQ-007 The block SHALL have port a_out, output, w bits: recovered unsigned input sample.
REQ-008 The block SHALL have port a_valid, output, 1 bit: a_out is valid this cycle.
REQ-009 The block SHALL have port err, output, 1 bit: sticky flag for an inconsistent sum stream.

Function
REQ-010 On each cycle with s_valid=1, the block SHALL compute x[k] = s[k] - s[k-1] + x[k-4] in w+3-bit signed arithmetic.
- s[k-1] is the previous accepted sum.
- x[k-4] is the fourth-previous recovered sample.
REQ-011 The block SHALL register x[k] (low w bits) into a_out and assert a_valid one cycle after the accepting edge; latency is exactly 1 cycle.
REQ-012 With s_valid=0, the block SHALL hold all history, hold a_out, and drive a_valid=0 on the next cycle.
REQ-013 After reset or clr, the block SHALL treat s[k-1] and x[k-1..k-4] as zero, matching the forward filter's zero-initialised pipeline.
REQ-014 clr SHALL take priority over s_valid in the same cycle: history zeroed, sample discarded, a_valid=0 next cycle; err is not affected.
REQ-015 The history SHALL shift by exactly one position per accepted sample, with no wrap-around artefacts; it is a 4-deep FIFO of recovered samples.
REQ-016 Back-to-back s_valid=1 SHALL be accepted every cycle with no bubbles.

Reset
REQ-017 While reset=1 at a rising edge:
- a_out SHALL be 0.
- a_valid SHALL be 0.
- err SHALL be 0.
- s[k-1] and all four history registers SHALL be 0.
REQ-018 Reset asserted mid-stream SHALL discard any sample presented in the same cycle.

Configuration
REQ-019 With macro FIR4_INV_CHECK_EN defined:
- err SHALL set one cycle after any accepted x[k] outside 0..2^w-1.
- err SHALL stay set until reset.
- The out-of-range value SHALL still be output truncated to w bits.
REQ-020 Without FIR4_INV_CHECK_EN, err SHALL be tied to 0 and no range-check logic SHALL be present.

Structure
REQ-021 Package fir4_pkg SHALL hold the following, shared with the forward filter and its benches:
- localparam TAPS=4.
- A function returning the sum width (w+2).
REQ-022 The history SHALL be a sub-module fir4_tap_delay, with parameters width and depth (=TAPS), and ports for shift enable, clear, data in, and the oldest-tap output.

Verification
REQ-023 Constant test (w=4): reset, then s = 5,10,15,20,20,20 with s_valid=1 -> a_out = 5 on each of the six following cycles; err=0.
REQ-024 Round-trip test: 25 random 4-bit samples through the forward filter model, with its output fed to s_in -> a_out equals the original sample sequence exactly, 1 cycle after each sum; err=0.
REQ-025 Stall test: s_valid toggled 1,0,0,1 mid-stream -> a_valid pulses only after accepted samples; recovered sequence is unchanged vs the no-stall run.
REQ-026 Clear test: clr asserted after 3 samples, stream restarted from the zero state -> recovery is correct with no contribution from pre-clr history.
REQ-027 Range-check test (FIR4_INV_CHECK_EN): first sum s=60 after reset -> a_out = 60 mod 16 = 12, err=1 next cycle, err held until reset; without the macro, err=0.
REQ-028 Reset test: reset pulsed mid-stream -> all outputs 0 next cycle; the following stream recovers correctly.
